bram_stream_ctrl: RTL and testbench

Upstream sequencer for the 2048x8 power-optimised BRAM/bypass mux stage. Accepts a byte stream, writes one frame of `FRAME_LEN` bytes into the BRAM, then drains it back in address order by driving the mux's `we`/`addr`/`din`/`sel`/`pass_ip` inputs. During fill, the incoming bytes can be mirrored through the mux bypass path. The block issues `sel` one cycle ahead of the read addresses to match the mux's 3-stage select pipeline against its 2-stage data path, and emits `out_valid`/`out_last` aligned with the mux `dout`.

---
 rtl/bram_stream_ctrl_if.sv | 30 +++
 rtl/bram_stream_ctrl.sv | 112 +++++++++++
 tb/tb_bram_stream_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_ctrl_if.sv
// Byte-stream input plus the write/read/select bus that drives the BRAM/bypass mux stage.
interface bram_stream_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              sel;
    logic [DATA_W-1:0] pass_ip;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic [15:0]       frame_cnt;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, addr, din, sel, pass_ip,
        output out_valid, out_last, busy, frame_cnt
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, addr, din, sel, pass_ip,
        input  out_valid, out_last, busy, frame_cnt
    );
endinterface

// File: rtl/bram_stream_ctrl.sv
// Fills one frame into the BRAM, then drains it in address order with sel leading reads by one cycle.
// Optional BRAM_STREAM_PASS_MON_EN: mirror accepted fill bytes through the bypass path with out_valid.
module bram_stream_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 2048
) (
    input  logic               clk,
    input  logic               rst,
    bram_stream_ctrl_if.master bus
);
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {FILL, PRE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] pass_q, pass_d;
    logic              vld_p0_q, vld_p1_q;
    logic              last_p0_q, last_p1_q;
    logic              rd_issue, rd_final, pass_tag;

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        pass_d       = pass_q;
        rd_issue     = 1'b0;
        rd_final     = 1'b0;
        pass_tag     = 1'b0;
        bus.in_ready = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = '0;
        bus.din      = '0;
        bus.sel      = 1'b0;
        case (state_q)
            FILL: begin
                bus.in_ready = 1'b1;
                bus.we       = bus.in_valid;
                bus.din      = bus.in_data;
                bus.addr     = wr_cnt_q[ADDR_W-1:0];
                if (bus.in_valid) begin
`ifdef BRAM_STREAM_PASS_MON_EN
                    pass_d   = bus.in_data;
                    pass_tag = 1'b1;
`endif
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = PRE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end
            end
            PRE: begin
                // sel goes high one cycle before the first read address
                bus.sel = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                bus.addr = rd_cnt_q[ADDR_W-1:0];
                rd_issue = 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    // drop sel early so the next fill beat's bypass byte follows the last drained byte
                    rd_final    = 1'b1;
                    rd_cnt_d    = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = FILL;
                end else begin
                    bus.sel  = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            frame_cnt_q <= '0;
            pass_q      <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            last_p0_q   <= 1'b0;
            last_p1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pass_q      <= pass_d;
            // stage p0 -> p1: tags track the mux's 2-cycle data latency
            vld_p0_q    <= rd_issue | pass_tag;
            vld_p1_q    <= vld_p0_q;
            last_p0_q   <= rd_final;
            last_p1_q   <= last_p0_q;
        end
    end

    assign bus.pass_ip   = pass_q;
    assign bus.out_valid = vld_p1_q;
    assign bus.out_last  = last_p1_q;
    assign bus.busy      = (state_q != FILL);
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Scoreboard bench: two controllers (4-byte and 2048-byte frames), each driving a behavioural mux model.
module tb_bram_stream_ctrl;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int NB = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_stream_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sa ();
    bram_stream_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sb ();

    bram_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(N)) dut_a (
        .clk(clk), .rst(rst), .bus(sa.master));
    bram_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(NB)) dut_b (
        .clk(clk), .rst(rst), .bus(sb.master));

    // Mux stage models: 2-stage data path, 3-stage select path, no reset
    logic [7:0] mem_a [0:2047];
    logic [7:0] mem_b [0:2047];
    logic [7:0] ram_a, dout_a, ram_b, dout_b;
    logic       sp0_a, sp1_a, sp0_b, sp1_b;

    always @(posedge clk) begin
        if (sa.we) mem_a[sa.addr] <= sa.din;
        ram_a  <= mem_a[sa.addr];
        sp0_a  <= sa.sel;
        sp1_a  <= sp0_a;
        dout_a <= sp1_a ? ram_a : sa.pass_ip;
        if (sb.we) mem_b[sb.addr] <= sb.din;
        ram_b  <= mem_b[sb.addr];
        sp0_b  <= sb.sel;
        sp1_b  <= sp0_b;
        dout_b <= sp1_b ? ram_b : sb.pass_ip;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards hold {last, data}
    logic [8:0] q_a [$];
    logic [8:0] q_b [$];
    logic [7:0] fb_a [$];
    int exp_wr_a     = 0;
    int exp_frames_a = 0;
    int ov_a         = 0;

    always @(negedge clk) begin : mon_a
        logic [8:0] e;
        if (rst === 1'b0) begin
            if (sa.out_valid === 1'b1) begin
                ov_a++;
                if (q_a.size() == 0) chk("a_unexp_valid", sa.out_valid, 0);
                else begin
                    e = q_a.pop_front();
                    chk("a_dout", dout_a, e[7:0]);
                    chk("a_last", sa.out_last, e[8]);
                end
            end else if (sa.out_last === 1'b1) begin
                chk("a_last_wo_valid", sa.out_last, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        if (rst === 1'b0 && sb.out_valid === 1'b1) begin
            if (q_b.size() == 0) chk("b_unexp_valid", sb.out_valid, 0);
            else begin
                e = q_b.pop_front();
                chk("b_dout", dout_b, e[7:0]);
                chk("b_last", sb.out_last, e[8]);
            end
        end
    end

    task automatic reset_chk();
        chk("rst_rdy", sa.in_ready, 1);
        chk("rst_we", sa.we, 0);
        chk("rst_sel", sa.sel, 0);
        chk("rst_addr", sa.addr, 0);
        chk("rst_pass", sa.pass_ip, 0);
        chk("rst_ov", sa.out_valid, 0);
        chk("rst_last", sa.out_last, 0);
        chk("rst_busy", sa.busy, 0);
        chk("rst_fcnt", sa.frame_cnt, 0);
    endtask

    task automatic send_a(input logic v, input logic [7:0] d);
        @(negedge clk);
        sa.in_valid = v;
        sa.in_data  = d;
        #1;
        chk("fill_rdy", sa.in_ready, 1);
        chk("fill_we", sa.we, v);
        chk("fill_addr", sa.addr, exp_wr_a);
        chk("fill_sel", sa.sel, 0);
        chk("fill_busy", sa.busy, 0);
        chk("fill_fcnt", sa.frame_cnt, exp_frames_a);
`ifndef BRAM_STREAM_PASS_MON_EN
        chk("pass_ip_idle", sa.pass_ip, 0);
`endif
        if (v) begin
`ifdef BRAM_STREAM_PASS_MON_EN
            q_a.push_back({1'b0, d});
`endif
            fb_a.push_back(d);
            exp_wr_a++;
            if (exp_wr_a == N) begin
                for (int i = 0; i < N; i++) q_a.push_back({(i == N - 1), fb_a[i]});
                fb_a.delete();
                exp_wr_a = 0;
            end
        end
    endtask

    task automatic drain_a(input logic hold, input logic abort);
        @(negedge clk);
        sa.in_valid = hold;
        sa.in_data  = 8'h5A;
        #1;
        chk("pre_rdy", sa.in_ready, 0);
        chk("pre_we", sa.we, 0);
        chk("pre_sel", sa.sel, 1);
        chk("pre_addr", sa.addr, 0);
        chk("pre_busy", sa.busy, 1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            #1;
            chk("dr_addr", sa.addr, i);
            chk("dr_sel", sa.sel, (i != N - 1));
            chk("dr_we", sa.we, 0);
            chk("dr_rdy", sa.in_ready, 0);
            chk("dr_busy", sa.busy, 1);
            if (abort && i == 1) begin
                #1;
                rst = 1'b1;
                #1;
                reset_chk();
                q_a.delete();
                fb_a.delete();
                exp_wr_a     = 0;
                exp_frames_a = 0;
                return;
            end
        end
        exp_frames_a++;
    endtask

    task automatic idle_a(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sa.in_valid = 1'b0;
            #1;
            chk("idle_fcnt", sa.frame_cnt, exp_frames_a);
        end
        chk("a_sb_empty", q_a.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int snap;
        logic [7:0] d;
        rst = 1'b1;
        sa.in_valid = 1'b0;
        sa.in_data  = '0;
        sb.in_valid = 1'b0;
        sb.in_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        reset_chk();
        @(negedge clk);
        rst = 1'b0;

        // Basic 4-byte frame, continuous valid
        send_a(1, 8'h11); send_a(1, 8'h22); send_a(1, 8'h33); send_a(1, 8'h44);
        drain_a(0, 0);
        idle_a(4);

        // Gapped valid during fill
        send_a(1, 8'hAA); send_a(0, 8'h00); send_a(1, 8'hBB); send_a(0, 8'h00);
        send_a(1, 8'hCC); send_a(0, 8'h00); send_a(1, 8'hDD);
        drain_a(0, 0);
        idle_a(4);

        // Single byte followed by idle, exercises the bypass monitor path
        send_a(1, 8'hA5); send_a(0, 8'h00); send_a(0, 8'h00); send_a(0, 8'h00);
        send_a(1, 8'hB6); send_a(1, 8'hC7); send_a(1, 8'hD8);
        drain_a(0, 0);
        idle_a(4);

        // Valid held high with 0x5A through PRE/DRAIN; next beat accepted right after final read
        send_a(1, 8'h01); send_a(1, 8'h02); send_a(1, 8'h03); send_a(1, 8'h04);
        drain_a(1, 0);
        send_a(1, 8'h5A); send_a(1, 8'h06); send_a(1, 8'h07); send_a(1, 8'h08);
        drain_a(0, 0);
        idle_a(4);

        // Reset in the second drain cycle
        send_a(1, 8'h21); send_a(1, 8'h22); send_a(1, 8'h23); send_a(1, 8'h24);
        drain_a(0, 1);
        @(negedge clk);
        rst = 1'b0;
        snap = ov_a;
        idle_a(6);
        chk("rst_quiet", ov_a - snap, 0);
        send_a(1, 8'h31); send_a(1, 8'h32); send_a(1, 8'h33); send_a(1, 8'h34);
        drain_a(0, 0);
        idle_a(4);

        // Full-depth frame on the 2048-byte instance
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            d = 8'(i * 7 + (i >> 8));
            sb.in_valid = 1'b1;
            sb.in_data  = d;
            #1;
            if (i == 0 || i == NB - 1) chk("b_fill_addr", sb.addr, i);
            if (i == NB - 1) chk("b_fill_rdy", sb.in_ready, 1);
`ifdef BRAM_STREAM_PASS_MON_EN
            q_b.push_back({1'b0, d});
`endif
        end
        for (int j = 0; j < NB; j++) q_b.push_back({(j == NB - 1), 8'(j * 7 + (j >> 8))});
        @(negedge clk);
        sb.in_valid = 1'b0;
        #1;
        chk("b_pre_sel", sb.sel, 1);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            #1;
            if (i == 0 || i == NB - 1) chk("b_dr_addr", sb.addr, i);
        end
        @(negedge clk);
        #1;
        chk("b_addr_wrap", sb.addr, 0);
        chk("b_fcnt", sb.frame_cnt, 1);
        chk("b_busy", sb.busy, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("b_sb_empty", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
